palette_init_loader: RTL and testbench

PALETTE_INIT_LOADER -- requirements
Module: palette_init_loader

---
 rtl/memdef.sv | 10 +
 rtl/palette_init_loader_pkg.sv | 26 ++
 rtl/palette_init_loader_rom.sv | 29 ++
 rtl/palette_init_loader.sv | 112 +++++++++++
 tb/tb_palette_init_loader.sv | 232 +++++++++++++++++++++++
 5 files changed

// File: rtl/memdef.sv
// rtl/memdef.sv - CPU-side memory map constants for the color file registers
package memdef;

  // CGB color file ports: spec (index/auto-increment) and data registers
  localparam logic [15:0] BCPS = 16'hFF68;
  localparam logic [15:0] BCPD = 16'hFF69;
  localparam logic [15:0] OCPS = 16'hFF6A;
  localparam logic [15:0] OCPD = 16'hFF6B;

endpackage

// File: rtl/palette_init_loader_pkg.sv
// rtl/palette_init_loader_pkg.sv - shared GPU types and constants for the palette loader
package palette_init_loader_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    BG_SPEC  = 3'd1,
    BG_DATA  = 3'd2,
    OBJ_SPEC = 3'd3,
    OBJ_DATA = 3'd4,
    DONE     = 3'd5
  } loader_state_e;

  // Spec register value: auto-increment enabled, starting at index 0
  localparam logic [7:0] PAL_SPEC_AUTOINC = 8'h80;

  // One spec write plus one data write per byte, for BG and OBJ
  localparam int unsigned PAL_WRITE_COUNT = 130;
  localparam int unsigned PAL_DATA_WRITES = (PAL_WRITE_COUNT - 2) / 2;
  localparam logic [5:0]  PAL_CNT_LAST    = 6'(PAL_DATA_WRITES - 1);

  // True in the states that issue a bus write when granted
  function automatic logic is_write_state(input loader_state_e s);
    return (s == BG_SPEC) || (s == BG_DATA) || (s == OBJ_SPEC) || (s == OBJ_DATA);
  endfunction

endpackage

// File: rtl/palette_init_loader_rom.sv
// rtl/palette_init_loader_rom.sv - combinational default BG/OBJ palette table
module palette_init_rom (
  input  logic [6:0] I_ADDR,
  output logic [7:0] O_DATA
);

  // Bytes 0-63 are the BG palettes, 64-127 the OBJ palettes (8 bytes per palette)
  localparam logic [7:0] ROM_TABLE [0:127] = '{
    8'h6F, 8'hFB, 8'h56, 8'hB5, 8'h4A, 8'h29, 8'h21, 8'h04,
    8'hFF, 8'h7F, 8'h94, 8'h52, 8'h08, 8'h21, 8'h00, 8'h00,
    8'hFF, 8'h7F, 8'h1F, 8'h42, 8'h0F, 8'h1C, 8'h00, 8'h00,
    8'hFF, 8'h7F, 8'hE0, 8'h03, 8'hA0, 8'h01, 8'h00, 8'h00,
    8'hFF, 8'h7F, 8'h7C, 8'h5E, 8'h18, 8'h3C, 8'h00, 8'h00,
    8'hFF, 8'h7F, 8'hFF, 8'h03, 8'h1F, 8'h00, 8'h00, 8'h00,
    8'hFF, 8'h7F, 8'h6B, 8'h2D, 8'h10, 8'h42, 8'h00, 8'h00,
    8'hFF, 8'h7F, 8'h5A, 8'h6B, 8'h31, 8'h46, 8'h00, 8'h00,
    8'h6F, 8'hFB, 8'h2A, 8'h56, 8'h94, 8'h52, 8'h00, 8'h00,
    8'hFF, 8'h7F, 8'h1F, 8'h00, 8'h10, 8'h00, 8'h00, 8'h00,
    8'hFF, 8'h7F, 8'hE0, 8'h7F, 8'h00, 8'h3C, 8'h00, 8'h00,
    8'hFF, 8'h7F, 8'h00, 8'h7C, 8'h00, 8'h40, 8'h00, 8'h00,
    8'hFF, 8'h7F, 8'hFF, 8'h7F, 8'h5A, 8'h6B, 8'h00, 8'h00,
    8'hFF, 8'h7F, 8'h3F, 8'h03, 8'h1F, 8'h02, 8'h00, 8'h00,
    8'hFF, 8'h7F, 8'hB5, 8'h56, 8'h4A, 8'h29, 8'h00, 8'h00,
    8'hFF, 8'h7F, 8'h31, 8'h46, 8'h08, 8'h21, 8'h1C, 8'hE7
  };

  assign O_DATA = ROM_TABLE[I_ADDR];

endmodule

// File: rtl/palette_init_loader.sv
// rtl/palette_init_loader.sv - writes the default BG/OBJ palettes into the color file
module palette_init_loader
  import memdef::*, palette_init_loader_pkg::*;
#(
  parameter bit AUTO_START = 1'b1
) (
  input  logic        I_CLK,
  input  logic        I_RESET,
  input  logic        I_START,
  input  logic        I_GRANT,
  output logic [15:0] O_MEMBUS_ADDR,
  output logic [7:0]  O_DATA,
  output logic        O_MEMBUS_WE_L,
  output logic        O_BUSY,
  output logic        O_DONE
);

  loader_state_e state, state_nxt;
  logic [5:0]    cnt, cnt_nxt;
  logic          auto_pend, auto_pend_nxt;
  logic [6:0]    rom_addr;
  logic [7:0]    rom_data;

  // BG bytes live in the lower half of the table, OBJ bytes in the upper half
  assign rom_addr = {(state == OBJ_DATA), cnt};

  palette_init_rom u_rom (
    .I_ADDR (rom_addr),
    .O_DATA (rom_data)
  );

  // State, byte counter and the one-shot auto-start request armed by reset
  always_ff @(posedge I_CLK or posedge I_RESET) begin
    if (I_RESET) begin
      state     <= IDLE;
      cnt       <= '0;
      auto_pend <= AUTO_START;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      auto_pend <= auto_pend_nxt;
    end
  end

  // Next state and bus outputs; a write only happens in a write state holding the grant
  always_comb begin
    state_nxt     = state;
    cnt_nxt       = cnt;
    auto_pend_nxt = auto_pend;
    O_MEMBUS_ADDR = 16'h0000;
    O_DATA        = 8'h00;
    O_MEMBUS_WE_L = 1'b1;

    unique case (state)
      IDLE, DONE: begin
        if (I_START || auto_pend) begin
          state_nxt     = BG_SPEC;
          cnt_nxt       = '0;
          auto_pend_nxt = 1'b0;
        end
      end
      BG_SPEC: begin
        if (I_GRANT) begin
          O_MEMBUS_ADDR = BCPS;
          O_DATA        = PAL_SPEC_AUTOINC;
          O_MEMBUS_WE_L = 1'b0;
          state_nxt     = BG_DATA;
          cnt_nxt       = '0;
        end
      end
      BG_DATA: begin
        if (I_GRANT) begin
          O_MEMBUS_ADDR = BCPD;
          O_DATA        = rom_data;
          O_MEMBUS_WE_L = 1'b0;
          cnt_nxt       = cnt + 6'd1;
          if (cnt == PAL_CNT_LAST) begin
            state_nxt = OBJ_SPEC;
          end
        end
      end
      OBJ_SPEC: begin
        if (I_GRANT) begin
          O_MEMBUS_ADDR = OCPS;
          O_DATA        = PAL_SPEC_AUTOINC;
          O_MEMBUS_WE_L = 1'b0;
          state_nxt     = OBJ_DATA;
          cnt_nxt       = '0;
        end
      end
      OBJ_DATA: begin
        if (I_GRANT) begin
          O_MEMBUS_ADDR = OCPD;
          O_DATA        = rom_data;
          O_MEMBUS_WE_L = 1'b0;
          cnt_nxt       = cnt + 6'd1;
          if (cnt == PAL_CNT_LAST) begin
            state_nxt = DONE;
          end
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  assign O_BUSY = is_write_state(state);
  assign O_DONE = (state == DONE);

endmodule

// File: tb/tb_palette_init_loader.sv
// tb/tb_palette_init_loader.sv - directed self-checking bench for palette_init_loader
module tb_palette_init_loader;
  import memdef::*;
  import palette_init_loader_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        start_a, grant_a, start_m, grant_m;
  logic [15:0] addr_a, addr_m;
  logic [7:0]  data_a, data_m;
  logic        we_a, we_m, busy_a, busy_m, done_a, done_m;

  palette_init_loader #(.AUTO_START(1'b1)) dut_a (
    .I_CLK(clk), .I_RESET(rst), .I_START(start_a), .I_GRANT(grant_a),
    .O_MEMBUS_ADDR(addr_a), .O_DATA(data_a), .O_MEMBUS_WE_L(we_a),
    .O_BUSY(busy_a), .O_DONE(done_a)
  );

  palette_init_loader #(.AUTO_START(1'b0)) dut_m (
    .I_CLK(clk), .I_RESET(rst), .I_START(start_m), .I_GRANT(grant_m),
    .O_MEMBUS_ADDR(addr_m), .O_DATA(data_m), .O_MEMBUS_WE_L(we_m),
    .O_BUSY(busy_m), .O_DONE(done_m)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  logic [23:0] log_a [$];
  logic [23:0] log_m [$];
  int   first_we_a, last_we_a, done_rise_a, busy_cnt_a, viol_a, viol_m;
  logic done_prev_a = 1'b0;

  logic [7:0] bg_mem [64];
  logic [7:0] ob_mem [64];
  logic [5:0] bg_idx, ob_idx;
  logic       bg_ai, ob_ai;

  typedef struct packed {
    int          idx;
    logic [15:0] addr;
    logic [7:0]  data;
  } vec_t;
  vec_t tbl [11];

  always @(posedge clk) cyc <= cyc + 1;

  // Write monitor and color file model, sampled mid-cycle
  always @(negedge clk) begin
    if (!rst) begin
      if (we_a == 1'b0) begin
        if (log_a.size() == 0) first_we_a = cyc;
        log_a.push_back({addr_a, data_a});
        last_we_a = cyc;
        if (!grant_a) viol_a++;
        case (addr_a)
          BCPS: begin bg_idx = data_a[5:0]; bg_ai = data_a[7]; end
          OCPS: begin ob_idx = data_a[5:0]; ob_ai = data_a[7]; end
          BCPD: begin bg_mem[bg_idx] = data_a; if (bg_ai) bg_idx = bg_idx + 6'd1; end
          OCPD: begin ob_mem[ob_idx] = data_a; if (ob_ai) ob_idx = ob_idx + 6'd1; end
          default: ;
        endcase
      end
      if (busy_a) busy_cnt_a++;
      if (done_a && !done_prev_a) done_rise_a = cyc;
      done_prev_a = done_a;
      if (we_m == 1'b0) begin
        log_m.push_back({addr_m, data_m});
        if (!grant_m) viol_m++;
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] exp_addr(input int i);
    if (i == 0) return BCPS;
    if (i <= 64) return BCPD;
    if (i == 65) return OCPS;
    return OCPD;
  endfunction

  task automatic check_log(input string tag, input logic [23:0] lg [$]);
    int bad;
    check({tag, "_count"}, lg.size(), 130);
    for (int v = 0; v < 11; v++) begin
      if (tbl[v].idx < lg.size())
        check($sformatf("%s_w%0d", tag, tbl[v].idx), lg[tbl[v].idx], {tbl[v].addr, tbl[v].data});
      else
        check($sformatf("%s_w%0d_missing", tag, tbl[v].idx), lg.size(), tbl[v].idx + 1);
    end
    bad = 0;
    for (int i = 0; i < lg.size(); i++)
      if (lg[i][23:8] != exp_addr(i)) bad++;
    check({tag, "_addr_order"}, bad, 0);
  endtask

  task automatic wait_done(input string name, input bit use_m, input int limit);
    for (int k = 0; k < limit; k++) begin
      @(negedge clk);
      #1;
      if (use_m ? done_m : done_a) break;
    end
    check({name, "_done_reached"}, use_m ? done_m : done_a, 1);
  endtask

  task automatic clear_a();
    log_a.delete();
    busy_cnt_a = 0;
    viol_a = 0;
    done_rise_a = -1;
    first_we_a = -1;
    last_we_a = -1;
  endtask

  initial begin
    tbl[0]  = '{idx: 0,   addr: BCPS, data: 8'h80};
    tbl[1]  = '{idx: 1,   addr: BCPD, data: 8'h6F};
    tbl[2]  = '{idx: 2,   addr: BCPD, data: 8'hFB};
    tbl[3]  = '{idx: 3,   addr: BCPD, data: 8'h56};
    tbl[4]  = '{idx: 63,  addr: BCPD, data: 8'h00};
    tbl[5]  = '{idx: 64,  addr: BCPD, data: 8'h00};
    tbl[6]  = '{idx: 65,  addr: OCPS, data: 8'h80};
    tbl[7]  = '{idx: 66,  addr: OCPD, data: 8'h6F};
    tbl[8]  = '{idx: 68,  addr: OCPD, data: 8'h2A};
    tbl[9]  = '{idx: 128, addr: OCPD, data: 8'h1C};
    tbl[10] = '{idx: 129, addr: OCPD, data: 8'hE7};

    rst = 1'b1; start_a = 1'b0; grant_a = 1'b1; start_m = 1'b0; grant_m = 1'b0;
    viol_m = 0;
    clear_a();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_we_a",   we_a,   1);
    check("rst_addr_a", addr_a, 0);
    check("rst_data_a", data_a, 0);
    check("rst_busy_a", busy_a, 0);
    check("rst_done_a", done_a, 0);
    check("rst_busy_m", busy_m, 0);

    // Auto start with grant held high
    @(posedge clk); #1 rst = 1'b0;
    wait_done("auto", 1'b0, 400);
    check_log("auto", log_a);
    check("auto_done_edge", done_rise_a, last_we_a + 1);
    check("auto_consecutive", last_we_a - first_we_a, 129);
    check("auto_no_grant_viol", viol_a, 0);
    check("auto_m_idle", busy_m, 0);
    check("auto_m_no_writes", log_m.size(), 0);
    check("cf_bg_p0c0", {bg_mem[0], bg_mem[1]}, 16'h6FFB);
    check("cf_bg_p7c3", {bg_mem[62], bg_mem[63]}, 16'h0000);
    check("cf_obj_p7c3", {ob_mem[62], ob_mem[63]}, 16'h1CE7);
    repeat (3) @(negedge clk);
    check("auto_done_hold", done_a, 1);
    check("auto_busy_low", busy_a, 0);

    // Grant toggling every cycle, low on the first busy cycle
    @(posedge clk); #1 rst = 1'b1; grant_a = 1'b0;
    clear_a();
    @(posedge clk); #1 rst = 1'b0;
    for (int i = 1; i <= 600; i++) begin
      @(posedge clk); #1 grant_a = (i % 2 == 0);
      if (done_a) break;
    end
    @(negedge clk); #1;
    check("toggle_done", done_a, 1);
    check("toggle_busy_cycles", busy_cnt_a, 260);
    check("toggle_no_grant_viol", viol_a, 0);
    check_log("toggle", log_a);

    // Reset in the middle of a run
    @(posedge clk); #1 rst = 1'b1; grant_a = 1'b1;
    clear_a();
    @(posedge clk); #1 rst = 1'b0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk); #1;
      if (log_a.size() >= 40) break;
    end
    check("midrst_reached_40", log_a.size(), 40);
    #1 rst = 1'b1;
    #1;
    check("midrst_we",   we_a,   1);
    check("midrst_busy", busy_a, 0);
    check("midrst_addr", addr_a, 0);
    check("midrst_data", data_a, 0);
    check("midrst_done", done_a, 0);
    clear_a();
    @(posedge clk); #1 rst = 1'b0;
    wait_done("midrst", 1'b0, 400);
    check_log("midrst", log_a);

    // Manual start, ignored start while busy, restart from DONE
    repeat (5) @(posedge clk);
    #1;
    check("man_wait_idle", busy_m, 0);
    check("man_no_writes", log_m.size(), 0);
    start_m = 1'b1; grant_m = 1'b1;
    @(negedge clk);
    check("man_start_no_we",   we_m,   1);
    check("man_start_no_addr", addr_m, 0);
    @(posedge clk); #1 start_m = 1'b0;
    check("man_busy_after_start", busy_m, 1);
    for (int k = 0; k < 200; k++) begin
      @(negedge clk); #1;
      if (log_m.size() >= 10) break;
    end
    @(posedge clk); #1 start_m = 1'b1;
    @(posedge clk); #1 start_m = 1'b0;
    wait_done("man", 1'b1, 400);
    check_log("man", log_m);
    check("man_no_grant_viol", viol_m, 0);
    log_m.delete();
    @(posedge clk); #1 start_m = 1'b1;
    @(posedge clk); #1 start_m = 1'b0;
    check("rerun_done_clear", done_m, 0);
    check("rerun_busy", busy_m, 1);
    wait_done("rerun", 1'b1, 400);
    check_log("rerun", log_m);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
